// File: rtl/cnt_date_pkg.sv
// Shared constants and BCD helpers for the day/month counter and its month-length decoder.
package cnt_date_pkg;

  localparam logic [7:0] MON_JAN = 8'h01;
  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_MAR = 8'h03;
  localparam logic [7:0] MON_APR = 8'h04;
  localparam logic [7:0] MON_MAY = 8'h05;
  localparam logic [7:0] MON_JUN = 8'h06;
  localparam logic [7:0] MON_JUL = 8'h07;
  localparam logic [7:0] MON_AUG = 8'h08;
  localparam logic [7:0] MON_SEP = 8'h09;
  localparam logic [7:0] MON_OCT = 8'h10;
  localparam logic [7:0] MON_NOV = 8'h11;
  localparam logic [7:0] MON_DEC = 8'h12;

  localparam logic [7:0] DAY_01 = 8'h01;
  localparam logic [7:0] DAY_28 = 8'h28;
  localparam logic [7:0] DAY_29 = 8'h29;
  localparam logic [7:0] DAY_30 = 8'h30;
  localparam logic [7:0] DAY_31 = 8'h31;

  localparam int RUN_BIT = 0;
  localparam int SET_BIT = 1;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Last legal day of a BCD month; shared so clamp targets follow the same rule as MAXDAY.
  function automatic logic [7:0] month_len(input logic [7:0] month, input logic leap);
    logic [7:0] r;
    case (month)
      MON_FEB:                           r = leap ? DAY_29 : DAY_28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: r = DAY_30;
      default:                           r = DAY_31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cnt_date_maxday.sv
// Month length and leap-year decode from a BCD month and the year counter's {hundreds,tens,ones}.
module cnt_date_maxday
  import cnt_date_pkg::*;
#(
  parameter bit CENTURY_LEAP = 1'b0
) (
  input  logic [7:0]  month,
  input  logic [11:0] year_bcd,
  output logic [7:0]  maxday,
  output logic        leap
);

  logic [3:0] hund, tens, ones;

  assign {hund, tens, ones} = year_bcd;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    leap = 1'b0;
    if (hund == 4'd0) begin
      // A two-digit year is divisible by 4 exactly when this tens-parity/ones pairing holds.
      if (!tens[0]) leap = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
      else          leap = (ones == 4'd2) || (ones == 4'd6);
    end else if (year_bcd == 12'h100) begin
      leap = CENTURY_LEAP;
    end
  end

  assign maxday = month_len(month, leap);

endmodule

// File: rtl/cnt_date.sv
// Day/month BCD counter between the hour and year counters; `define CNT_DATE_DEC_EN adds DEC_MODE.
module cnt_date
  import cnt_date_pkg::*;
#(
  parameter logic [7:0] RESET_DAY_BCD   = 8'h01,
  parameter logic [7:0] RESET_MONTH_BCD = 8'h01,
  parameter bit         CENTURY_LEAP    = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        CARRY_in,
  input  logic [1:0]  SET_CURRENT_STATE,
  input  logic        INC_MODE,
`ifdef CNT_DATE_DEC_EN
  input  logic        DEC_MODE,
`endif
  input  logic        SET_SEL,
  input  logic [11:0] YEAR_BCD,
  output logic [3:0]  DAY10,
  output logic [3:0]  DAY1,
  output logic [3:0]  MON10,
  output logic [3:0]  MON1,
  output logic        LEAP,
  output logic        CARRY_out
);

  logic [7:0] day, month;
  logic [7:0] day_nxt, month_nxt;
  logic [7:0] maxday, month_step, step_maxday;
  logic       run_adv, set_up, set_down, day_at_max, leap_loss;

  cnt_date_maxday #(.CENTURY_LEAP(CENTURY_LEAP)) u_maxday (
    .month    (month),
    .year_bcd (YEAR_BCD),
    .maxday   (maxday),
    .leap     (LEAP)
  );

  assign run_adv = ENABLE & CARRY_in & SET_CURRENT_STATE[RUN_BIT] & ~SET_CURRENT_STATE[SET_BIT];

`ifdef CNT_DATE_DEC_EN
  assign set_up   = SET_CURRENT_STATE[SET_BIT] & INC_MODE & ~DEC_MODE;
  assign set_down = SET_CURRENT_STATE[SET_BIT] & DEC_MODE & ~INC_MODE;
`else
  assign set_up   = SET_CURRENT_STATE[SET_BIT] & INC_MODE;
  assign set_down = 1'b0;
`endif

  assign day_at_max = (day == maxday);
  assign leap_loss  = (month == MON_FEB) && (day == DAY_29) && !LEAP;
  assign CARRY_out  = run_adv & day_at_max & (month == MON_DEC);

  // Neighbouring month for any month change this cycle, and its length for the day clamp.
  assign month_step = set_down ? ((month == MON_JAN) ? MON_DEC : bcd_dec(month))
                               : ((month == MON_DEC) ? MON_JAN : bcd_inc(month));
  assign step_maxday = month_len(month_step, LEAP);

  always_comb begin
    day_nxt   = day;
    month_nxt = month;
    if (leap_loss) begin
      day_nxt = DAY_28;
    end else if (set_up || set_down) begin
      if (!SET_SEL) begin
        if (set_down) day_nxt = (day == DAY_01) ? maxday : bcd_dec(day);
        else          day_nxt = day_at_max ? DAY_01 : bcd_inc(day);
      end else begin
        month_nxt = month_step;
        day_nxt   = (day > step_maxday) ? step_maxday : day;
      end
    end else if (run_adv) begin
      if (day_at_max) begin
        day_nxt   = DAY_01;
        month_nxt = month_step;
      end else begin
        day_nxt = bcd_inc(day);
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      day   <= RESET_DAY_BCD;
      month <= RESET_MONTH_BCD;
    end else begin
      day   <= day_nxt;
      month <= month_nxt;
    end
  end

  assign {DAY10, DAY1} = day;
  assign {MON10, MON1} = month;

endmodule

// File: tb/tb_cnt_date.sv
// Self-checking bench for cnt_date: calendar-arithmetic model compared every cycle plus directed literal checks.
module tb_cnt_date;

  localparam bit CENTURY_LEAP = 1'b0;
  localparam int MLEN [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        ENABLE = 1'b0;
  logic        CARRY_in = 1'b0;
  logic [1:0]  SET_CURRENT_STATE = 2'b00;
  logic        INC_MODE = 1'b0;
`ifdef CNT_DATE_DEC_EN
  logic        DEC_MODE = 1'b0;
`endif
  logic        SET_SEL = 1'b0;
  logic [11:0] YEAR_BCD = 12'h024;
  logic [3:0]  DAY10, DAY1, MON10, MON1;
  logic        LEAP, CARRY_out;

  int checks = 0;
  int errors = 0;
  int m_day = 1;
  int m_mon = 1;

  cnt_date #(
    .RESET_DAY_BCD   (8'h01),
    .RESET_MONTH_BCD (8'h01),
    .CENTURY_LEAP    (CENTURY_LEAP)
  ) dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .ENABLE            (ENABLE),
    .CARRY_in          (CARRY_in),
    .SET_CURRENT_STATE (SET_CURRENT_STATE),
    .INC_MODE          (INC_MODE),
`ifdef CNT_DATE_DEC_EN
    .DEC_MODE          (DEC_MODE),
`endif
    .SET_SEL           (SET_SEL),
    .YEAR_BCD          (YEAR_BCD),
    .DAY10             (DAY10),
    .DAY1              (DAY1),
    .MON10             (MON10),
    .MON1              (MON1),
    .LEAP              (LEAP),
    .CARRY_out         (CARRY_out)
  );

  initial forever #5 CLK = ~CLK;

  function automatic int year_of(input logic [11:0] y);
    return int'(y[11:8]) * 100 + int'(y[7:4]) * 10 + int'(y[3:0]);
  endfunction

  function automatic bit is_leap(input logic [11:0] y);
    int yr;
    yr = year_of(y);
    return (yr < 100 && yr % 4 == 0) || (yr == 100 && CENTURY_LEAP);
  endfunction

  function automatic int days_in(input int mon, input bit lp);
    return (mon == 2 && lp) ? 29 : MLEN[mon - 1];
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_date(input string tag, input logic [7:0] d, input logic [7:0] m);
    check({tag, " day"}, 32'({DAY10, DAY1}), 32'(d));
    check({tag, " month"}, 32'({MON10, MON1}), 32'(m));
  endtask

  // Calendar model: next date from plain integer arithmetic on day/month numbers.
  always @(posedge CLK or negedge RESET_N) begin : model
    int nd, nm, mx, sx;
    bit lp, up, down;
    if (!RESET_N) begin
      m_day <= 1;
      m_mon <= 1;
    end else begin
      lp   = is_leap(YEAR_BCD);
      mx   = days_in(m_mon, lp);
      nd   = m_day;
      nm   = m_mon;
      up   = SET_CURRENT_STATE[1] && INC_MODE;
      down = 1'b0;
`ifdef CNT_DATE_DEC_EN
      down = SET_CURRENT_STATE[1] && DEC_MODE;
      if (up && down) begin
        up   = 1'b0;
        down = 1'b0;
      end
`endif
      if (m_mon == 2 && m_day == 29 && !lp) begin
        nd = 28;
      end else if (up || down) begin
        if (!SET_SEL) begin
          nd = up ? ((m_day == mx) ? 1 : m_day + 1) : ((m_day == 1) ? mx : m_day - 1);
        end else begin
          nm = up ? (m_mon % 12 + 1) : ((m_mon == 1) ? 12 : m_mon - 1);
          sx = days_in(nm, lp);
          if (nd > sx) nd = sx;
        end
      end else if (SET_CURRENT_STATE == 2'b01 && ENABLE && CARRY_in) begin
        if (m_day == mx) begin
          nd = 1;
          nm = m_mon % 12 + 1;
        end else begin
          nd = m_day + 1;
        end
      end
      m_day <= nd;
      m_mon <= nm;
    end
  end

  always @(negedge CLK) begin
    bit exp_carry;
    exp_carry = (SET_CURRENT_STATE == 2'b01) && ENABLE && CARRY_in &&
                (m_day == days_in(m_mon, is_leap(YEAR_BCD))) && (m_mon == 12);
    check("cmp day", 32'({DAY10, DAY1}), 32'(to_bcd(m_day)));
    check("cmp month", 32'({MON10, MON1}), 32'(to_bcd(m_mon)));
    check("cmp leap", 32'(LEAP), 32'(is_leap(YEAR_BCD)));
    check("cmp carry", 32'(CARRY_out), 32'(exp_carry));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    SET_CURRENT_STATE = 2'b00;
    ENABLE = 1'b0;
    CARRY_in = 1'b0;
    INC_MODE = 1'b0;
    SET_SEL = 1'b0;
`ifdef CNT_DATE_DEC_EN
    DEC_MODE = 1'b0;
`endif
  endtask

  task automatic set_step(input logic sel);
    SET_CURRENT_STATE = 2'b10;
    SET_SEL = sel;
    INC_MODE = 1'b1;
    tick();
  endtask

  task automatic run_step();
    SET_CURRENT_STATE = 2'b01;
    ENABLE = 1'b1;
    CARRY_in = 1'b1;
    tick();
    idle();
  endtask

  // Reset to 01/01, then walk the month and day up with SET increments.
  task automatic goto_date(input int mon, input int day);
    idle();
    RESET_N = 1'b0;
    #1;
    RESET_N = 1'b1;
    for (int i = 1; i < mon; i++) set_step(1'b1);
    for (int i = 1; i < day; i++) set_step(1'b0);
    idle();
  endtask

  initial begin
    #1;
    RESET_N = 1'b0;
    tick();
    tick();
    expect_date("reset", 8'h01, 8'h01);
    check("reset carry", 32'(CARRY_out), 32'd0);
    RESET_N = 1'b1;
    tick();

    // Leap year: 28 Feb -> 29 Feb -> 01 Mar.
    YEAR_BCD = 12'h024;
    goto_date(2, 28);
    expect_date("leap start", 8'h28, 8'h02);
    run_step();
    expect_date("leap 29feb", 8'h29, 8'h02);
    run_step();
    expect_date("leap 01mar", 8'h01, 8'h03);

    // Common year: 28 Feb -> 01 Mar.
    YEAR_BCD = 12'h023;
    goto_date(2, 28);
    run_step();
    expect_date("common 01mar", 8'h01, 8'h03);

    // Year end: carry in the wrap cycle, gone afterwards.
    goto_date(12, 31);
    SET_CURRENT_STATE = 2'b01;
    ENABLE = 1'b1;
    CARRY_in = 1'b1;
    #1;
    check("dec31 carry", 32'(CARRY_out), 32'd1);
    tick();
    idle();
    expect_date("new year", 8'h01, 8'h01);
    check("new year carry", 32'(CARRY_out), 32'd0);

    // SET month wraps 12 -> 01 without changing the day.
    goto_date(12, 5);
    set_step(1'b1);
    idle();
    expect_date("set mon wrap", 8'h05, 8'h01);

    // Century year not leap: 31 Jan SET month -> 28 Feb.
    YEAR_BCD = 12'h100;
    goto_date(1, 31);
    check("century leap", 32'(LEAP), 32'd0);
    SET_CURRENT_STATE = 2'b10;
    SET_SEL = 1'b1;
    INC_MODE = 1'b1;
    #1;
    check("set carry", 32'(CARRY_out), 32'd0);
    tick();
    idle();
    expect_date("clamp 28feb", 8'h28, 8'h02);

    // Leap loss: 29 Feb stays until the year changes, then becomes 28.
    YEAR_BCD = 12'h024;
    goto_date(2, 29);
    SET_CURRENT_STATE = 2'b01;
    tick();
    expect_date("hold 29feb", 8'h29, 8'h02);
    YEAR_BCD = 12'h025;
    #1;
    check("leap drop", 32'(LEAP), 32'd0);
    tick();
    expect_date("leap loss", 8'h28, 8'h02);
    idle();

    // Both mode bits: SET wins, day wraps inside April.
    goto_date(4, 30);
    SET_CURRENT_STATE = 2'b11;
    ENABLE = 1'b1;
    CARRY_in = 1'b1;
    INC_MODE = 1'b1;
    SET_SEL = 1'b0;
    #1;
    check("both carry", 32'(CARRY_out), 32'd0);
    tick();
    idle();
    expect_date("both 01apr", 8'h01, 8'h04);

    // Asynchronous reset in the middle of running.
    goto_date(3, 10);
    SET_CURRENT_STATE = 2'b01;
    ENABLE = 1'b1;
    CARRY_in = 1'b1;
    tick();
    tick();
    tick();
    expect_date("run 13mar", 8'h13, 8'h03);
    #1;
    RESET_N = 1'b0;
    #1;
    expect_date("mid reset", 8'h01, 8'h01);
    check("mid reset carry", 32'(CARRY_out), 32'd0);
    idle();
    RESET_N = 1'b1;
    tick();

`ifdef CNT_DATE_DEC_EN
    goto_date(1, 31);
    SET_CURRENT_STATE = 2'b10;
    SET_SEL = 1'b1;
    DEC_MODE = 1'b1;
    tick();
    idle();
    expect_date("dec 31dec", 8'h31, 8'h12);
    goto_date(1, 1);
    SET_CURRENT_STATE = 2'b10;
    SET_SEL = 1'b0;
    DEC_MODE = 1'b1;
    tick();
    idle();
    expect_date("dec day wrap", 8'h31, 8'h01);
    SET_CURRENT_STATE = 2'b10;
    INC_MODE = 1'b1;
    DEC_MODE = 1'b1;
    tick();
    idle();
    expect_date("inc dec hold", 8'h31, 8'h01);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
